march_bist_ctrl: RTL
====================

Name: march_bist_ctrl

Overview:
- March C- BIST controller for the 256x4 single-port synchronous SRAM; sits directly upstream of the array.
- Drives its address, write-enable and write data, and checks the registered read data against expected values.
- Reports pass/fail with a first-failure capture and a saturating error count.
- Runs on the same clock as the SRAM; read latency is 1 cycle: data_out updates on the edge that samples WE=0.

Parameters:
- ADDR_W, 8, SRAM address width; depth = 2**ADDR_W.
- DATA_W, 4, SRAM word width; backgrounds are all-0s and all-1s.
- CNT_W, 8, width of the saturating failure counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled only in IDLE or DONE.
- sram_addr  out  ADDR_W  to SRAM Address.
- sram_we  out  1  to SRAM WE; 1 = write, 0 = read.
- sram_din  out  DATA_W  to SRAM data_in.
- sram_dout  in  DATA_W  from SRAM data_out; registered, 1-cycle latency.
- busy  out  1  test in progress.
- done  out  1  sticky: test finished.
- fail  out  1  sticky: at least one mismatch.
- fail_addr  out  ADDR_W  address of first mismatch.
- fail_exp  out  DATA_W  expected word at first mismatch.
- fail_got  out  DATA_W  read word at first mismatch.
- fail_elem  out  3  march element (0-5) of first mismatch.
- fail_count  out  CNT_W  mismatches; saturates at all-1s.

Behaviour:
- Reset, asynchronous, any state including mid-run:
  - State = IDLE.
  - All outputs 0: sram_we=0, sram_addr=0, sram_din=0, busy=0, done=0, fail=0, all capture registers 0, fail_count=0.
  - The compare pipeline is cleared.
- States: IDLE, M0..M5, FLUSH, DONE.
- IDLE/DONE with start=1 at an edge:
  - Clears done, fail, captures and count.
  - Sets busy; goes to M0 with addr=0.
  - A start held high after DONE restarts the test.
  - start is ignored in every other state.
- Elements (w = write cycle with sram_we=1; r = read cycle with sram_we=0; one op per cycle):
  - M0 up: w0.
  - M1 up: r0, w1.
  - M2 up: r1, w0.
  - M3 down: r0, w1.
  - M4 down: r1, w0.
  - M5 up: r0.
- Two-op elements use a phase bit: the read of address a is followed immediately by the write of the same a, then the address steps.
- Address counter:
  - Up elements run 0 to 2**ADDR_W-1; down elements run 2**ADDR_W-1 to 0.
  - On the last address of an element, go to the next element with the address preloaded to its start (M3 starts at max; M5 starts at 0).
  - No wrap-around ever occurs within an element.
- sram_din = 0 for w0 and all-1s for w1; it is 0 during read cycles.
- Compare pipeline:
  - On a read cycle, register chk_v=1, exp (0 or all-1s), addr and elem.
  - Next cycle, compare sram_dout with exp when chk_v=1.
  - Mismatch with fail=0: set fail; capture fail_addr/fail_exp/fail_got/fail_elem.
  - Every mismatch: fail_count+1, saturating; later mismatches never overwrite the captures.
- After the M5 read of the last address, go to FLUSH (sram_we=0, one cycle, final compare), then DONE.
- In DONE: busy=0, done=1; results are held until start or reset.
- Total: 2560 op cycles + 1 FLUSH. With the start-sampling edge as E0, busy=1 after E0 and done=1 after E0+2561.
- Outside M0..M5: sram_we=0, sram_din=0, sram_addr=0.

Test Plan:
- Fault-free SRAM, pulse start -> busy for 2561 cycles; done=1 at E0+2561; fail=0; fail_count=0; exactly 1280 write cycles and 1280 read cycles seen on the SRAM interface.
- Bit 2 at address 0x05 stuck-at-0 -> fail=1, fail_elem=2, fail_addr=0x05, fail_exp=4'hF, fail_got=4'hB, fail_count=2 (M2, M4).
- Bit 0 at address 0xFF stuck-at-1 -> fail_elem=1, fail_addr=0xFF, fail_exp=4'h0, fail_got=4'h1, fail_count=3 (M1, M3, M5).
- Drop rst_n at op cycle 700 (inside M1) -> same cycle: sram_we=0, busy=0, all results 0; after release, start runs a full clean pass with done at E0+2561.
- Pulse start at op cycles 10 and 1500 -> ignored; done timing unchanged. After done, assert start again -> done and fail clear on that edge and a new run begins.
- Every cell stuck-at-0 in all bits -> fail_count saturates at 8'hFF; captures stay at the first failure: elem 2, addr 0x00.

Source files
------------

// File: rtl/march_bist_ctrl_if.sv
// Bus between the March C- BIST controller, its 256x4 SRAM and the host.
// The controller side uses the master modport.
interface march_bist_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we;
  logic [DATA_W-1:0] sram_din;
  logic [DATA_W-1:0] sram_dout;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_exp;
  logic [DATA_W-1:0] fail_got;
  logic [2:0]        fail_elem;
  logic [CNT_W-1:0]  fail_count;

  modport master (
    input  start, sram_dout,
    output sram_addr, sram_we, sram_din, busy, done, fail,
           fail_addr, fail_exp, fail_got, fail_elem, fail_count
  );

  modport slave (
    output start, sram_dout,
    input  sram_addr, sram_we, sram_din, busy, done, fail,
           fail_addr, fail_exp, fail_got, fail_elem, fail_count
  );
endinterface

// File: rtl/march_bist_ctrl.sv
// March C- BIST controller for a single-port SRAM with 1-cycle read latency.
// Sequences M0..M5, compares read data one cycle later and records the first failure.
module march_bist_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  march_bist_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_M0    = 4'd0,
    S_M1    = 4'd1,
    S_M2    = 4'd2,
    S_M3    = 4'd3,
    S_M4    = 4'd4,
    S_M5    = 4'd5,
    S_FLUSH = 4'd6,
    S_DONE  = 4'd7,
    S_IDLE  = 4'd8
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ONES = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic is_march(input state_t s);
    case (s)
      S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic two_op(input state_t s);
    case (s)
      S_M1, S_M2, S_M3, S_M4: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic is_down(input state_t s);
    case (s)
      S_M3, S_M4: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Background written by the element (w1 in M1 and M3)
  function automatic logic wr_ones(input state_t s);
    case (s)
      S_M1, S_M3: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic rd_ones(input state_t s);
    case (s)
      S_M2, S_M4: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic state_t next_elem(input state_t s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      S_M5:    return S_FLUSH;
      default: return S_IDLE;
    endcase
  endfunction

  // Phase 1 of a two-op element is its write; M0 is write-only, M5 read-only
  function automatic logic is_write(input state_t s, input logic phase);
    return is_march(s) && ((s == S_M0) || (two_op(s) && phase));
  endfunction

  state_t            state_r, state_nx_s;
  logic [ADDR_W-1:0] addr_r, addr_nx_s, elem_end_s;
  logic              phase_r, phase_nx_s;
  logic              start_go_s;

  logic              we_nx_s, busy_nx_s, rd_s, mismatch_s;
  logic [DATA_W-1:0] din_nx_s, rd_exp_s;
  logic [ADDR_W-1:0] addr_out_nx_s;

  logic [ADDR_W-1:0] sram_addr_r;
  logic              sram_we_r;
  logic [DATA_W-1:0] sram_din_r;
  logic              busy_r, done_r;

  logic              chk_v_r;
  logic [DATA_W-1:0] chk_exp_r;
  logic [ADDR_W-1:0] chk_addr_r;
  logic [2:0]        chk_elem_r;

  logic              fail_r;
  logic [ADDR_W-1:0] fail_addr_r;
  logic [DATA_W-1:0] fail_exp_r, fail_got_r;
  logic [2:0]        fail_elem_r;
  logic [CNT_W-1:0]  fail_count_r;

  // State, address and phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      addr_r  <= ADDR_ZERO;
      phase_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      addr_r  <= addr_nx_s;
      phase_r <= phase_nx_s;
    end
  end

  // Next-state: element sequencing, read/write phase and address stepping
  always_comb begin
    state_nx_s = state_r;
    addr_nx_s  = addr_r;
    phase_nx_s = phase_r;
    start_go_s = 1'b0;
    elem_end_s = is_down(state_r) ? ADDR_ZERO : ADDR_MAX;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          start_go_s = 1'b1;
          state_nx_s = S_M0;
          addr_nx_s  = ADDR_ZERO;
          phase_nx_s = 1'b0;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
        if (two_op(state_r) && !phase_r) begin
          phase_nx_s = 1'b1;
        end else begin
          phase_nx_s = 1'b0;
          if (addr_r == elem_end_s) begin
            state_nx_s = next_elem(state_r);
            addr_nx_s  = is_down(next_elem(state_r)) ? ADDR_MAX : ADDR_ZERO;
          end else if (is_down(state_r)) begin
            addr_nx_s = addr_r - ADDR_ONE;
          end else begin
            addr_nx_s = addr_r + ADDR_ONE;
          end
        end
      end
      S_FLUSH: state_nx_s = S_DONE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Output decode: next SRAM command from the next state, plus compare inputs
  always_comb begin
    we_nx_s       = is_write(state_nx_s, phase_nx_s);
    din_nx_s      = (we_nx_s && wr_ones(state_nx_s)) ? DATA_ONES : DATA_ZERO;
    addr_out_nx_s = is_march(state_nx_s) ? addr_nx_s : ADDR_ZERO;
    busy_nx_s     = is_march(state_nx_s) || (state_nx_s == S_FLUSH);
    rd_s          = is_march(state_r) && !is_write(state_r, phase_r);
    rd_exp_s      = rd_ones(state_r) ? DATA_ONES : DATA_ZERO;
    mismatch_s    = chk_v_r && (bus.sram_dout != chk_exp_r);
  end

  // Registered SRAM command and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr_r <= ADDR_ZERO;
      sram_we_r   <= 1'b0;
      sram_din_r  <= DATA_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      sram_addr_r <= addr_out_nx_s;
      sram_we_r   <= we_nx_s;
      sram_din_r  <= din_nx_s;
      busy_r      <= busy_nx_s;
      done_r      <= (state_nx_s == S_DONE);
    end
  end

  // Compare pipeline: remembers what the read just issued should return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_v_r    <= 1'b0;
      chk_exp_r  <= DATA_ZERO;
      chk_addr_r <= ADDR_ZERO;
      chk_elem_r <= 3'd0;
    end else begin
      chk_v_r    <= rd_s;
      chk_exp_r  <= rd_exp_s;
      chk_addr_r <= addr_r;
      chk_elem_r <= state_r[2:0];
    end
  end

  // Result registers: first-failure capture and saturating mismatch count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_r       <= 1'b0;
      fail_addr_r  <= ADDR_ZERO;
      fail_exp_r   <= DATA_ZERO;
      fail_got_r   <= DATA_ZERO;
      fail_elem_r  <= 3'd0;
      fail_count_r <= CNT_ZERO;
    end else if (start_go_s) begin
      fail_r       <= 1'b0;
      fail_addr_r  <= ADDR_ZERO;
      fail_exp_r   <= DATA_ZERO;
      fail_got_r   <= DATA_ZERO;
      fail_elem_r  <= 3'd0;
      fail_count_r <= CNT_ZERO;
    end else if (mismatch_s) begin
      fail_r <= 1'b1;
      if (!fail_r) begin
        fail_addr_r <= chk_addr_r;
        fail_exp_r  <= chk_exp_r;
        fail_got_r  <= bus.sram_dout;
        fail_elem_r <= chk_elem_r;
      end else begin
        fail_addr_r <= fail_addr_r;
      end
      if (fail_count_r != CNT_MAX) begin
        fail_count_r <= fail_count_r + CNT_ONE;
      end else begin
        fail_count_r <= fail_count_r;
      end
    end else begin
      fail_r <= fail_r;
    end
  end

  assign bus.sram_addr  = sram_addr_r;
  assign bus.sram_we    = sram_we_r;
  assign bus.sram_din   = sram_din_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.fail       = fail_r;
  assign bus.fail_addr  = fail_addr_r;
  assign bus.fail_exp   = fail_exp_r;
  assign bus.fail_got   = fail_got_r;
  assign bus.fail_elem  = fail_elem_r;
  assign bus.fail_count = fail_count_r;

endmodule
